// File: rtl/dpram_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_arbiter_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 32;

  // INIT clears the RAM after reset, RUN serves requesters.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Pointer width that still works for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request at or after the pointer.
// Latency: grant is combinational in the request cycle; pointer moves on the next edge.
// Backpressure: the pointer only advances when adv is high and a grant was produced.
module rr_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int PW = ptr_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic [PW-1:0] ptr_nxt;

  // Scan requesters starting at the priority pointer, take the first one asserted.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any      = 1'b1;
        gnt[cand] = 1'b1;
        idx      = cand;
      end
    end
  end

  // The requester after the winner becomes highest priority (wrapping at N-1).
  always_comb begin
    ptr_nxt = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
  end

  // Pointer holds when nothing was granted or the caller withdrew the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && any) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one simple dual-port RAM among NUM_REQ requesters, clearing it after reset.
// Latency: grants same cycle as request; rd_valid/rd_data one cycle after rd_gnt.
// Backpressure: ungranted requesters must hold their request; reads colliding with the granted write wait a cycle.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      ram_wen,
  output logic [ADDR_W-1:0]         ram_waddr,
  output logic [DATA_W-1:0]         ram_din,
  output logic                      ram_ren,
  output logic [ADDR_W-1:0]         ram_raddr,
  input  logic [DATA_W-1:0]         ram_dout,
  output logic                      init_done
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                run;

  logic [ADDR_W-1:0]   wa_arr [NUM_REQ];
  logic [DATA_W-1:0]   wd_arr [NUM_REQ];
  logic [ADDR_W-1:0]   ra_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  r_req;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [NUM_REQ-1:0]  r_cand;
  logic [PW-1:0]       w_idx;
  logic [PW-1:0]       r_idx;
  logic                w_any;
  logic                r_any;
  logic                hazard;

  // Unpack the flat request buses into per-requester views.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wa_arr[i] = wr_addr[i*ADDR_W +: ADDR_W];
    assign wd_arr[i] = wr_data[i*DATA_W +: DATA_W];
    assign ra_arr[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Clear sequencer: walk every address once, then serve requesters until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  assign run   = (state == ST_RUN);
  assign w_req = wr_req & {NUM_REQ{run}};
  assign r_req = rd_req & {NUM_REQ{run}};

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .adv   (1'b1),
    .gnt   (w_gnt),
    .idx   (w_idx),
    .any   (w_any)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (r_req),
    .adv   (~hazard),
    .gnt   (r_cand),
    .idx   (r_idx),
    .any   (r_any)
  );

  // A read of the word being written this cycle would return stale data, so it waits.
  always_comb begin
    hazard = w_any && r_any && (ra_arr[r_idx] == wa_arr[w_idx]);
  end

  // Grants and RAM port muxing; INIT owns the write port for clearing.
  always_comb begin
    wr_gnt    = w_gnt;
    rd_gnt    = hazard ? '0 : r_cand;
    ram_ren   = r_any && !hazard;
    ram_raddr = ra_arr[r_idx];
    if (run) begin
      ram_wen   = w_any;
      ram_waddr = wa_arr[w_idx];
      ram_din   = wd_arr[w_idx];
    end else begin
      ram_wen   = 1'b1;
      ram_waddr = clr_cnt;
      ram_din   = '0;
    end
  end

  // Read data comes back one cycle after the grant; tag it with the requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_gnt;
    end
  end

  assign rd_data = ram_dout;

endmodule

// File: tb/tb_dpram_arbiter.sv
module tb_dpram_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    wr_req;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_gnt;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            ram_wen;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_din;
  logic            ram_ren;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_dout;
  logic            init_done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  dpram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // RAM attached to the DUT, pre-filled with a non-zero pattern so clearing is visible.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_q;
  assign ram_dout = ram_q;

  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_waddr] <= ram_din;
    if (ram_ren) ram_q <= ram_mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  bit            m_run;
  int            m_cnt;
  int            m_wptr;
  int            m_rptr;
  logic [N-1:0]  m_rvld;
  bit            m_done;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'hA5A5_0000 | i;
      m_mem[i]   = 32'hA5A5_0000 | i;
    end
    m_run = 0; m_cnt = 0; m_wptr = 0; m_rptr = 0;
    m_rvld = '0; m_done = 0; m_rdata = '0;
  end

  // Model and compare: outputs mid-cycle, then advance the model as of the next edge.
  always @(negedge clk) begin
    int w, r, ii;
    bit haz;
    logic [N-1:0]  e_wg, e_rg;
    logic          e_wen, e_ren;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_din;
    if (chk_en) begin
      w = -1; r = -1; haz = 0;
      e_wg = '0; e_rg = '0; e_raddr = '0;
      if (!m_run) begin
        e_wen = 1'b1; e_waddr = AW'(m_cnt); e_din = '0; e_ren = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          ii = (m_wptr + k) % N;
          if (w < 0 && wr_req[ii]) w = ii;
          ii = (m_rptr + k) % N;
          if (r < 0 && rd_req[ii]) r = ii;
        end
        e_waddr = (w >= 0) ? wr_addr[w*AW +: AW] : '0;
        e_din   = (w >= 0) ? wr_data[w*DW +: DW] : '0;
        if (r >= 0) e_raddr = rd_addr[r*AW +: AW];
        haz = (w >= 0) && (r >= 0) && (e_raddr == e_waddr);
        if (w >= 0) e_wg[w] = 1'b1;
        if (r >= 0 && !haz) e_rg[r] = 1'b1;
        e_wen = (w >= 0);
        e_ren = (e_rg != '0);
      end
      chk("wr_gnt", wr_gnt, e_wg);
      chk("rd_gnt", rd_gnt, e_rg);
      chk("rd_valid", rd_valid, m_rvld);
      chk("init_done", init_done, m_done);
      chk("ram_wen", ram_wen, e_wen);
      chk("ram_ren", ram_ren, e_ren);
      if (e_wen) begin
        chk("ram_waddr", ram_waddr, e_waddr);
        chk("ram_din", ram_din, e_din);
      end
      if (e_ren) chk("ram_raddr", ram_raddr, e_raddr);
      if (m_rvld != '0) chk("rd_data", rd_data, m_rdata);

      if (!rst_n) begin
        m_run = 0; m_cnt = 0; m_wptr = 0; m_rptr = 0; m_rvld = '0; m_done = 0;
      end else begin
        if (e_ren) m_rdata = m_mem[e_raddr];
        if (e_wen) m_mem[e_waddr] = e_din;
        m_rvld = e_rg;
        if (!m_run) begin
          if (m_cnt == DEPTH - 1) begin
            m_run = 1; m_done = 1;
          end
          m_cnt = (m_cnt + 1) % DEPTH;
        end else begin
          if (w >= 0) m_wptr = (w + 1) % N;
          if (e_rg != '0) m_rptr = (r + 1) % N;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    wr_req = '0; rd_req = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    step();
    chk_en = 1'b1;
    step();
    step();
    #2;
    chk("rst_ram_wen", ram_wen, 1);
    chk("rst_init_done", init_done, 0);
    #1;
    rst_n = 1'b1;

    // Requests during clearing must not be granted.
    wr_req = 2'b11; rd_req = 2'b11;
    set_wr(0, 10'd7, 32'h1111_1111); set_wr(1, 10'd8, 32'h2222_2222);
    set_rd(0, 10'd3); set_rd(1, 10'd4);
    n = 0;
    while (n < 2000) begin
      step();
      n++;
      if (n == 1000) begin wr_req = '0; rd_req = '0; end
      if (init_done) break;
    end
    chk("init_cycles", n, 1024);

    // Single write then read-back by requester 0.
    wr_req = 2'b01; set_wr(0, 10'd5, 32'hDEAD_BEEF);
    #2;
    chk("wr5_gnt", wr_gnt, 2'b01);
    chk("wr5_addr", ram_waddr, 5);
    step();
    wr_req = '0; rd_req = 2'b01; set_rd(0, 10'd5);
    #2;
    chk("rd5_gnt", rd_gnt, 2'b01);
    step();
    rd_req = '0;
    #2;
    chk("rd5_valid", rd_valid, 2'b01);
    chk("rd5_data", rd_data, 32'hDEAD_BEEF);

    // Same-address write (req 1) and read (req 0): read waits one cycle.
    step();
    wr_req = 2'b10; set_wr(1, 10'd9, 32'h1234_5678);
    rd_req = 2'b01; set_rd(0, 10'd9);
    #2;
    chk("haz_wr_gnt", wr_gnt, 2'b10);
    chk("haz_rd_gnt", rd_gnt, 2'b00);
    chk("haz_ram_ren", ram_ren, 0);
    step();
    wr_req = '0;
    #2;
    chk("haz_rd_retry", rd_gnt, 2'b01);
    step();
    rd_req = '0;
    #2;
    chk("haz_rd_valid", rd_valid, 2'b01);
    chk("haz_rd_data", rd_data, 32'h1234_5678);

    // Both writers held for four cycles.
    for (int k = 0; k < 4; k++) begin
      step();
      wr_req = 2'b11;
      set_wr(0, 10'd20, 32'hA000_0000 + k);
      set_wr(1, 10'd21, 32'hB000_0000 + k);
      #2;
      chk("wr_rr_seq", wr_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Single read by requester 1 realigns the read pointer to 0.
    step();
    wr_req = '0; rd_req = 2'b10; set_rd(1, 10'd20);
    #2;
    chk("rd1_gnt", rd_gnt, 2'b10);

    // Both readers held for four cycles, with unrelated writes alongside.
    for (int k = 0; k < 4; k++) begin
      step();
      rd_req = 2'b11; set_rd(0, 10'd21); set_rd(1, 10'd20);
      wr_req = 2'b01; set_wr(0, AW'(30 + k), 32'hC000_0000 + k);
      #2;
      chk("rd_rr_seq", rd_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 0) chk("rd20_data", rd_data, 32'hA000_0002);
      if (k == 1) chk("rd21_data", rd_data, 32'hB000_0003);
    end
    step();
    rd_req = '0; wr_req = '0;
    #2;
    chk("rd_last_valid", rd_valid, 2'b10);

    // Reset in the middle of clearing restarts from address 0.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr_req = 2'b11; rd_req = 2'b01; set_rd(0, 10'd1);
    n = 0;
    while (n < 2000) begin
      step();
      #2;
      n++;
      if (ram_waddr == 10'd500) break;
    end
    chk("clr_at_500", ram_waddr, 500);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #2;
    chk("clr_restart_addr", ram_waddr, 0);
    chk("clr_restart_wen", ram_wen, 1);
    chk("clr_restart_done", init_done, 0);
    n = 0;
    while (n < 2000) begin
      step();
      n++;
      if (n == 500) begin wr_req = '0; rd_req = '0; end
      if (init_done) break;
    end
    chk("reinit_cycles", n, 1024);

    // Address 5 was cleared by the second init.
    rd_req = 2'b01; set_rd(0, 10'd5);
    step();
    rd_req = '0;
    #2;
    chk("rd5_cleared_valid", rd_valid, 2'b01);
    chk("rd5_cleared_data", rd_data, 0);

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the RAM.
REQ-002 Parameter ADDR_W, default 10: RAM address width (1024 words).
REQ-003 Parameter DATA_W, default 32: RAM data width.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, synchronous, active-low.
REQ-006 wr_req  in  NUM_REQ: per-requester write request.
REQ-007 wr_addr  in  NUM_REQ*ADDR_W: packed write addresses, requester i at slice i.
REQ-008 wr_data  in  NUM_REQ*DATA_W: packed write data.
REQ-009 wr_gnt  out  NUM_REQ: one-hot write grant; the write transfers when wr_req[i] and wr_gnt[i] are both high.
REQ-010 rd_req  in  NUM_REQ: per-requester read request.
REQ-011 rd_addr  in  NUM_REQ*ADDR_W: packed read addresses.
REQ-012 rd_gnt  out  NUM_REQ: one-hot read grant.
REQ-013 rd_valid  out  NUM_REQ: the read data is for requester i.
REQ-014 rd_data  out  DATA_W: read data, broadcast to all requesters.
REQ-015 ram_wen, ram_waddr, ram_din  out  1/ADDR_W/DATA_W: RAM write port.
REQ-016 ram_ren, ram_raddr  out  1/ADDR_W: RAM read port.
REQ-017 ram_dout  in  DATA_W: RAM read data, valid exactly 1 cycle after ram_ren.
REQ-018 init_done  out  1: high once RAM clearing is complete.

Function
REQ-019 The FSM SHALL have states INIT and RUN; reset enters INIT with clear counter = 0.
REQ-020 In INIT: ram_wen=1, ram_waddr=counter, ram_din=0, counter +1 per cycle; after address 2^ADDR_W-1 is written, go to RUN.
REQ-021 Clearing SHALL take exactly 2^ADDR_W cycles (1024 by default); init_done SHALL be registered and rise the cycle RUN is entered.
REQ-022 In INIT, all wr_gnt, rd_gnt and rd_valid SHALL be 0 and ram_ren SHALL be 0.
REQ-023 In RUN, the write port and the read port SHALL each be arbitrated independently, round-robin, every cycle.
REQ-024 Grants SHALL be combinational in the same cycle as the request; a grant is only given to an asserted request.
REQ-025 Round-robin: a priority pointer (initially 0) names the highest-priority requester; after a grant to i the pointer becomes (i+1) mod NUM_REQ; it is unchanged when no grant is given.
REQ-026 ram_wen, ram_waddr and ram_din SHALL be muxed from the write winner; ram_wen=0 when there is no write winner.
REQ-027 ram_ren and ram_raddr SHALL be muxed from the read winner.
REQ-028 rd_valid[i] SHALL be asserted exactly 1 cycle after rd_gnt[i]; rd_data=ram_dout.
REQ-029 Hazard: if the read winner's address equals the granted write address in the same cycle, the read SHALL be denied that cycle (rd_gnt=0, ram_ren=0) and the read pointer SHALL NOT advance; the write proceeds.
REQ-030 Requests held continuously SHALL each be served within NUM_REQ cycles, the hazard case excepted.

Reset
REQ-031 While rst_n=0 at a clk edge: FSM=INIT, counter=0, both pointers=0, rd_valid=0, init_done=0; reset during INIT or RUN SHALL restart clearing from address 0.
REQ-032 Combinational outputs SHALL follow the INIT state after reset: wr_gnt=0, rd_gnt=0, ram_ren=0, ram_wen=1.

Structure
REQ-033 Package dpram_arbiter_pkg SHALL hold the default ADDR_W/DATA_W/NUM_REQ constants and the FSM state typedef.
REQ-034 Sub-module rr_arbiter (request vector in, one-hot grant out, pointer register, advance enable) SHALL be instanced twice, once for write and once for read.

Verification
REQ-035 Reset released -> ram_wen=1 for 1024 cycles at addresses 0..1023 with din=0; init_done=1 on cycle 1024; no grants before that.
REQ-036 Requester 0 writes 0xDEADBEEF to address 5, then reads address 5 -> rd_valid[0] one cycle after rd_gnt[0], rd_data=0xDEADBEEF.
REQ-037 Both wr_req held for 4 cycles -> wr_gnt sequence 01,10,01,10 (bit 0 first); the same applies to reads.
REQ-038 Write by requester 1 to address 9 and read by requester 0 of address 9 in the same cycle -> rd_gnt=0 that cycle, read granted the next cycle returns the new data.
REQ-039 rst_n pulsed low at clear address 500 -> clearing restarts at 0; init_done stays 0 for a further 1024 cycles.
